regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: EX (ALU result) and MEM (load result).
- Uses round-robin arbitration with a registered write stage that drives the regfile's rd, write_data and wr_en inputs.
- Holds a busy scoreboard of destination registers with outstanding loads, so issue logic can stall on RAW hazards against rs1/rs2.

---
 rtl/regfile_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between EX and MEM, tracks loads in flight.
// Latency: one cycle from an accepted request to wr_en/rd/write_data; rs1_busy/rs2_busy are combinational.
// Backpressure: round-robin grant; the losing requester sees ready=0 and holds valid, rd and data stable.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   ex_valid/ex_rd/ex_data/ex_ready      EX (ALU) writeback request and accept
//   mem_valid/mem_rd/mem_data/mem_ready  MEM (load) writeback request and accept
//   sb_set/sb_rd         mark a load destination busy
//   flush                clear the whole busy scoreboard
//   rs1_addr/rs2_addr    hazard lookup addresses -> rs1_busy/rs2_busy
//   rd/write_data/wr_en  registered write port driving the register file
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            sb_set,
  input  logic [4:0]      sb_rd,
  input  logic            flush,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic            wr_en
);

  // 1 when MEM was the most recently accepted requester; reset value lets EX win the first tie.
  logic            last_grant_mem;
  logic            grant_ex;
  logic            grant_mem;
  logic            accept;
  logic [4:0]      req_rd;
  logic [XLEN-1:0] req_data;
  logic [NREGS-1:0] busy;

  // Grant is combinational. Readies are held low during reset so nothing is
  // consumed while the write stage cannot record it.
  always_comb begin
    grant_ex  = 1'b0;
    grant_mem = 1'b0;
    if (!reset) begin
      if (ex_valid && mem_valid) begin
        grant_ex  = last_grant_mem;
        grant_mem = !last_grant_mem;
      end else begin
        grant_ex  = ex_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign ex_ready  = grant_ex;
  assign mem_ready = grant_mem;
  assign accept    = grant_ex | grant_mem;

  always_comb begin
    req_rd   = mem_rd;
    req_data = mem_data;
    if (grant_ex) begin
      req_rd   = ex_rd;
      req_data = ex_data;
    end
  end

  // Round-robin pointer moves only on an accepted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_mem <= 1'b1;
    end else if (accept) begin
      last_grant_mem <= grant_mem;
    end
  end

  // Write stage. A write to x0 is consumed but never raises wr_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd         <= '0;
      write_data <= '0;
      wr_en      <= 1'b0;
    end else if (accept) begin
      rd         <= req_rd;
      write_data <= req_data;
      wr_en      <= (req_rd != 5'd0);
    end else begin
      wr_en      <= 1'b0;
    end
  end

  // Busy scoreboard. The clear uses the write currently on the port, which the
  // register file captures on the same edge. A set on the same edge wins since
  // it represents a newer load to that register. busy[0] is never set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (sb_set && (sb_rd == 5'(r))) begin
          busy[r] <= 1'b1;
        end else if (wr_en && (rd == 5'(r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // No bypass from the write stage: a register reads busy until the edge that writes it.
  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, mem_valid, sb_set, flush;
  logic [4:0]  ex_rd, mem_rd, sb_rd, rs1_addr, rs2_addr, rd;
  logic [31:0] ex_data, mem_data, write_data;
  logic        ex_ready, mem_ready, rs1_busy, rs2_busy, wr_en;

  regfile_wb_arbiter #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .sb_set(sb_set), .sb_rd(sb_rd), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd(rd), .write_data(write_data), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  // Scoreboard queues: one entry per cycle, pushed by the driver, popped by the monitor.
  logic [1:0] rq[$];   // {ex_ready, mem_ready}
  logic [1:0] bq[$];   // {rs1_busy, rs2_busy}
  wr_t        wq[$];   // write port contents expected in that cycle

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit mon_en   = 0;

  // Reference model state.
  bit          m_busy[32];
  int          last_served;      // 0 = EX, 1 = MEM
  wr_t         m_cur;            // write port contents in the current cycle
  logic [31:0] m_rf[32];
  logic [31:0] tb_rf[32];        // simple register file fed by the DUT's write port

  // Requester agents: a request stays pending until accepted.
  bit          ex_pend, mem_pend;
  logic [4:0]  ex_prd, mem_prd;
  logic [31:0] ex_pdata, mem_pdata;

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_rf[i]  = '0;
      tb_rf[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (wr_en && rd != 5'd0) tb_rf[rd] <= write_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every cycle on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rq.size() == 0 || bq.size() == 0 || wq.size() == 0) begin
        chk_cnt++;
        $display("FAIL scoreboard_underflow: queues empty at t=%0t", $time);
      end else begin
        logic [1:0] r;
        logic [1:0] b;
        wr_t        w;
        r = rq.pop_front();
        b = bq.pop_front();
        w = wq.pop_front();
        check("ex_ready",   {63'd0, ex_ready},  {63'd0, r[1]});
        check("mem_ready",  {63'd0, mem_ready}, {63'd0, r[0]});
        check("rs1_busy",   {63'd0, rs1_busy},  {63'd0, b[1]});
        check("rs2_busy",   {63'd0, rs2_busy},  {63'd0, b[0]});
        check("wr_en",      {63'd0, wr_en},     {63'd0, w.en});
        check("rd",         {59'd0, rd},        {59'd0, w.rd});
        check("write_data", {32'd0, write_data}, {32'd0, w.data});
        check("rf_read",    {32'd0, tb_rf[rs1_addr]}, {32'd0, m_rf[rs1_addr]});
        if (w.en) m_rf[w.rd] = w.data;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    last_served = 1;
    m_cur = '0;
    rq.delete();
    bq.delete();
    wq.delete();
    wq.push_back(m_cur);
  endtask

  task automatic req_ex(input logic [4:0] r, input logic [31:0] d);
    ex_pend = 1; ex_prd = r; ex_pdata = d;
  endtask

  task automatic req_mem(input logic [4:0] r, input logic [31:0] d);
    mem_pend = 1; mem_prd = r; mem_pdata = d;
  endtask

  // One cycle: drive inputs shortly after the rising edge, predict, advance.
  task automatic step(input bit s_set, input logic [4:0] s_rd, input bit fl,
                      input logic [4:0] a1, input logic [4:0] a2);
    bit  w_ex, w_mem;
    wr_t nxt;
    ex_valid  = ex_pend;  ex_rd  = ex_prd;  ex_data  = ex_pdata;
    mem_valid = mem_pend; mem_rd = mem_prd; mem_data = mem_pdata;
    sb_set = s_set; sb_rd = s_rd; flush = fl;
    rs1_addr = a1; rs2_addr = a2;

    // Sole requester always wins; on a tie the one not served last wins.
    w_ex = 0; w_mem = 0;
    if (ex_pend && mem_pend) begin
      if (last_served == 0) w_mem = 1; else w_ex = 1;
    end else begin
      w_ex  = ex_pend;
      w_mem = mem_pend;
    end
    rq.push_back({w_ex, w_mem});
    bq.push_back({m_busy[a1], m_busy[a2]});

    nxt = m_cur;
    nxt.en = 1'b0;
    if (w_ex)  begin nxt.rd = ex_prd;  nxt.data = ex_pdata;  nxt.en = (ex_prd != 0);  end
    if (w_mem) begin nxt.rd = mem_prd; nxt.data = mem_pdata; nxt.en = (mem_prd != 0); end
    wq.push_back(nxt);

    if (fl) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (m_cur.en) m_busy[m_cur.rd] = 1'b0;
      if (s_set && s_rd != 0) m_busy[s_rd] = 1'b1;
    end

    m_cur = nxt;
    if (w_ex)  begin ex_pend = 0;  last_served = 0; end
    if (w_mem) begin mem_pend = 0; last_served = 1; end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic [4:0] a1);
    for (int i = 0; i < n; i++) step(0, 5'd0, 0, a1, 5'd0);
  endtask

  // Assert reset mid-cycle; wr_en must fall at once and all state must clear.
  task automatic reset_check(input string tag);
    mon_en = 0;
    reset = 1'b1;
    #1;
    check({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
    check({tag, "_rd"}, {59'd0, rd}, 64'd0);
    check({tag, "_write_data"}, {32'd0, write_data}, 64'd0);
    for (int r = 0; r < 32; r++) begin
      rs1_addr = 5'(r);
      rs2_addr = 5'(31 - r);
      #0.1;
      check({tag, "_busy"}, {62'd0, rs1_busy, rs2_busy}, 64'd0);
    end
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
    mon_en = 1;
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 0; mem_valid = 0; sb_set = 0; flush = 0;
    ex_rd = 0; mem_rd = 0; sb_rd = 0; rs1_addr = 0; rs2_addr = 0;
    ex_data = 0; mem_data = 0;
    ex_pend = 0; mem_pend = 0; ex_prd = 0; mem_prd = 0; ex_pdata = 0; mem_pdata = 0;

    // Both requesters present throughout reset; EX must win the first tie.
    req_ex(5'd1, 32'h11);
    req_mem(5'd2, 32'h22);
    ex_valid = 1; ex_rd = 5'd1; ex_data = 32'h11;
    mem_valid = 1; mem_rd = 5'd2; mem_data = 32'h22;
    repeat (2) @(posedge clk);
    #1;
    reset_check("reset");

    step(0, 5'd0, 0, 5'd1, 5'd2);     // EX granted
    step(0, 5'd0, 0, 5'd1, 5'd2);     // MEM granted, rd=1 written
    idle(1, 5'd1);                    // rd=2 written, x1 reads 0x11
    idle(1, 5'd2);                    // x2 reads 0x22

    // Load to x5: busy until the edge after its write is presented.
    step(1, 5'd5, 0, 5'd5, 5'd0);
    idle(1, 5'd5);
    req_mem(5'd5, 32'hDEADBEEF);
    idle(4, 5'd5);

    // Writes and loads targeting x0.
    req_ex(5'd0, 32'hFFFFFFFF);
    step(1, 5'd0, 0, 5'd0, 5'd0);
    idle(2, 5'd0);

    // Set and clear of x7 on the same edge: set wins.
    step(1, 5'd7, 0, 5'd7, 5'd0);
    req_ex(5'd7, 32'h77);
    step(0, 5'd0, 0, 5'd7, 5'd0);
    req_ex(5'd3, 32'h33);
    step(1, 5'd7, 0, 5'd7, 5'd0);     // wr_en=1 rd=7 with sb_set 7
    step(1, 5'd9, 1, 5'd7, 5'd9);     // flush beats sb_set 9; x3 write still fires
    idle(2, 5'd9);
    idle(1, 5'd3);

    // Sustained contention: strict alternation.
    for (int i = 0; i < 8; i++) begin
      if (!ex_pend)  req_ex(5'($urandom_range(1, 31)), $urandom);
      if (!mem_pend) req_mem(5'($urandom_range(1, 31)), $urandom);
      step(0, 5'd0, 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) reset_check("midreset");
      if (!ex_pend && ($urandom_range(0, 99) < 55))
        req_ex(5'($urandom_range(0, 31)), $urandom);
      if (!mem_pend && ($urandom_range(0, 99) < 45))
        req_mem(5'($urandom_range(0, 31)), $urandom);
      step(($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 99) < 3),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    idle(3, 5'd0);

    mon_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
